// File: rtl/trigger_conditioner.sv
// trigger_conditioner
//   Turns a raw, bouncy, asynchronous push-button into a clean debounced
//   `trigger` level and single-cycle `trigger_pulse` events, with optional
//   auto-repeat while the button is held.
//   Pipeline: 2-FF synchroniser -> debounce counter -> press/hold/repeat FSM.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   btn_in         raw button, asynchronous, active-high
//   enable         synchronous enable; 0 forces the FSM to IDLE
//   trigger        debounced button level (registered)
//   trigger_pulse  one-cycle pulse on each accepted press and each auto-repeat
//   press_count    accepted presses (repeats excluded), wraps 255 -> 0
//   state_dbg      FSM state: IDLE=0 PRESS_WAIT=1 PRESSED=2 REPEAT=3 RELEASE_WAIT=4
module trigger_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       enable,
  output logic       trigger,
  output logic       trigger_pulse,
  output logic [7:0] press_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DLY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PER_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);
  localparam bit RPT_EN  = (REPEAT_DELAY > 0);

  logic                 s1, s2;
  logic                 btn_sync;
  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [CNT_WIDTH-1:0] rpt, rpt_n;
  logic                 trig_n, pulse_n;
  logic [7:0]           count_n;
  // Set once a low sample has been seen while enabled; a button still held
  // when enable returns must be released before it can be accepted again.
  logic                 armed, armed_n;
  logic                 do_press, do_release;

  assign btn_sync  = s2;
  assign state_dbg = state;

  // Synchroniser runs regardless of enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rpt           <= '0;
      trigger       <= 1'b0;
      trigger_pulse <= 1'b0;
      press_count   <= 8'd0;
      armed         <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      rpt           <= rpt_n;
      trigger       <= trig_n;
      trigger_pulse <= pulse_n;
      press_count   <= count_n;
      armed         <= armed_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rpt_n      = rpt;
    trig_n     = trigger;
    pulse_n    = 1'b0;
    count_n    = press_count;
    armed_n    = armed;
    do_press   = 1'b0;
    do_release = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      rpt_n   = '0;
      trig_n  = 1'b0;
      armed_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!btn_sync) begin
            armed_n = 1'b1;
          end else if (armed) begin
            if (DEB_ONE) begin
              do_press = 1'b1;
            end else begin
              state_n = PRESS_WAIT;
              cnt_n   = CNT_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == DEB_LAST) begin
            do_press = 1'b1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            do_release = 1'b1;
          end else if (RPT_EN && (rpt == DLY_LAST)) begin
            state_n = REPEAT;
            pulse_n = 1'b1;
            rpt_n   = '0;
          end else if (RPT_EN) begin
            rpt_n = rpt + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!btn_sync) begin
            do_release = 1'b1;
          end else if (rpt == PER_LAST) begin
            pulse_n = 1'b1;
            rpt_n   = '0;
          end else begin
            rpt_n = rpt + CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // A high sample here is release bounce: restart the repeat delay.
          if (btn_sync) begin
            state_n = PRESSED;
            rpt_n   = '0;
            cnt_n   = '0;
          end else if (cnt == DEB_LAST) begin
            state_n = IDLE;
            trig_n  = 1'b0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          rpt_n   = '0;
          trig_n  = 1'b0;
        end
      endcase

      if (do_press) begin
        state_n = PRESSED;
        trig_n  = 1'b1;
        pulse_n = 1'b1;
        count_n = press_count + 8'd1;
        rpt_n   = '0;
        cnt_n   = '0;
      end

      // Release sampling wins over a same-cycle repeat: pulse_n stays 0 here
      // because the repeat branches are not taken when btn_sync is low.
      if (do_release) begin
        if (DEB_ONE) begin
          state_n = IDLE;
          trig_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_ONE;
        end
      end
    end
  end

endmodule
